// File: rtl/irq_pc_sequencer.sv
// irq_pc_sequencer: next-PC selection with interrupt entry, pipeline drain and mret return
module irq_pc_sequencer #(
    parameter int          N_IRQ        = 4,
    parameter logic [31:0] IRQ_BASE     = 32'h0000_0100,
    parameter int          DRAIN_CYCLES = 2,
    localparam int         CW           = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
    input  logic             i_clk,
    input  logic             in_rst,
    input  logic [31:0]      i_pc,
    input  logic             i_stall,
    input  logic             i_br_taken,
    input  logic [31:0]      i_br_target,
    input  logic             i_mret,
    input  logic             i_ie,
    input  logic [N_IRQ-1:0] i_irq,
    output logic [31:0]      o_nxt_pc,
    output logic             o_pc_enable,
    output logic             o_flush,
    output logic [N_IRQ-1:0] o_irq_ack,
    output logic [31:0]      o_epc,
    output logic [CW-1:0]    o_cause,
    output logic             o_in_isr
);
    typedef enum logic [1:0] {RUN, DRAIN, ENTER, ISR} state_t;
    state_t state, state_n;
    logic [31:0]      seq_pc, nxt_pc, epc_n;
    logic [CW-1:0]    cause_c, cause_n;
    logic [3:0]       cnt, cnt_n;
    logic [N_IRQ-1:0] ack_n;
    logic             pending, pc_en, flush, in_isr_n;
    assign seq_pc  = i_br_taken ? i_br_target : i_pc + 32'd4;
    assign pending = i_ie & |i_irq & ~o_in_isr;
    // lowest-numbered active request wins
    always_comb begin
        cause_c = '0;
        for (int i = N_IRQ - 1; i >= 0; i--)
            if (i_irq[i]) cause_c = CW'(i);
    end
    // next state, PC selection and register next values
    always_comb begin
        state_n  = state;
        nxt_pc   = seq_pc;
        pc_en    = 1'b0;
        flush    = 1'b0;
        epc_n    = o_epc;
        cause_n  = o_cause;
        cnt_n    = cnt;
        in_isr_n = o_in_isr;
        ack_n    = '0;
        case (state)
            RUN: begin
                if (pending) begin
                    if (!i_stall) begin
                        epc_n   = seq_pc;
                        cause_n = cause_c;
                        cnt_n   = 4'(DRAIN_CYCLES);
                        state_n = DRAIN;
                    end
                end else begin
                    pc_en = ~i_stall;
                end
            end
            DRAIN: begin
                flush = 1'b1;
                if (!i_stall) begin
                    cnt_n = cnt - 4'd1;
                    if (cnt == 4'd1) state_n = ENTER;
                end
            end
            ENTER: begin
                nxt_pc         = IRQ_BASE + (32'(o_cause) << 4);
                pc_en          = 1'b1;
                flush          = 1'b1;
                ack_n[o_cause] = 1'b1;
                in_isr_n       = 1'b1;
                state_n        = ISR;
            end
            ISR: begin
                if (i_mret) begin
                    nxt_pc = o_epc;
                    if (!i_stall) begin
                        pc_en    = 1'b1;
                        flush    = 1'b1;
                        in_isr_n = 1'b0;
                        state_n  = RUN;
                    end
                end else begin
                    pc_en = ~i_stall;
                end
            end
            default: state_n = RUN;
        endcase
    end
    // outputs forced quiet while reset is held
    assign o_nxt_pc    = in_rst ? nxt_pc : '0;
    assign o_pc_enable = in_rst & pc_en;
    assign o_flush     = in_rst & flush;
    // sequencer state and interrupt context registers
    always_ff @(posedge i_clk or negedge in_rst) begin
        if (!in_rst) begin
            state     <= RUN;
            o_epc     <= '0;
            o_cause   <= '0;
            o_in_isr  <= 1'b0;
            o_irq_ack <= '0;
            cnt       <= '0;
        end else begin
            state     <= state_n;
            o_epc     <= epc_n;
            o_cause   <= cause_n;
            o_in_isr  <= in_isr_n;
            o_irq_ack <= ack_n;
            cnt       <= cnt_n;
        end
    end
endmodule

// File: tb/tb_irq_pc_sequencer.sv
// tb_irq_pc_sequencer: vector table plus scoreboarded interrupt entry/return sequences
module tb_irq_pc_sequencer;
    logic        i_clk = 1'b0;
    logic        in_rst, i_stall, i_br_taken, i_mret, i_ie;
    logic [31:0] i_pc, i_br_target;
    logic [3:0]  i_irq;
    logic [31:0] o_nxt_pc, o_epc;
    logic        o_pc_enable, o_flush, o_in_isr;
    logic [3:0]  o_irq_ack;
    logic [1:0]  o_cause;

    irq_pc_sequencer dut (
        .i_clk(i_clk), .in_rst(in_rst), .i_pc(i_pc), .i_stall(i_stall),
        .i_br_taken(i_br_taken), .i_br_target(i_br_target), .i_mret(i_mret),
        .i_ie(i_ie), .i_irq(i_irq), .o_nxt_pc(o_nxt_pc), .o_pc_enable(o_pc_enable),
        .o_flush(o_flush), .o_irq_ack(o_irq_ack), .o_epc(o_epc), .o_cause(o_cause),
        .o_in_isr(o_in_isr)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {logic [31:0] nxt; logic care; logic en; logic fl;} out_t;
    typedef struct packed {
        logic stall; logic br; logic [31:0] tgt; logic [31:0] pc;
        logic mret; logic ie; logic [3:0] irq;
        logic [31:0] nxt; logic en; logic fl;
    } vec_t;

    out_t sb[$];
    vec_t tbl[9];
    int   n_chk = 0, n_fail = 0, found;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drv(input logic stall, input logic br, input logic [31:0] tgt, input logic [31:0] pc,
                       input logic mret, input logic ie, input logic [3:0] irq);
        i_stall = stall; i_br_taken = br; i_br_target = tgt; i_pc = pc;
        i_mret = mret; i_ie = ie; i_irq = irq;
    endtask

    task automatic pop_chk(input string nm);
        out_t e;
        if (sb.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL %s: scoreboard empty", nm);
        end else begin
            e = sb.pop_front();
            if (e.care) chk({nm, "_nxt"}, o_nxt_pc, e.nxt);
            chk({nm, "_en"}, 32'(o_pc_enable), 32'(e.en));
            chk({nm, "_flush"}, 32'(o_flush), 32'(e.fl));
        end
    endtask

    // drive one cycle of stimulus, queue its expected outputs, then sample mid-cycle
    task automatic cyc(input string nm, input logic stall, input logic br, input logic [31:0] tgt,
                       input logic [31:0] pc, input logic mret, input logic ie, input logic [3:0] irq,
                       input logic [31:0] nxt, input logic care, input logic en, input logic fl);
        drv(stall, br, tgt, pc, mret, ie, irq);
        sb.push_back('{nxt: nxt, care: care, en: en, fl: fl});
        #3;
        pop_chk(nm);
    endtask

    initial begin
        //         stall br  tgt           pc            mret ie  irq     nxt           en  fl
        tbl[0] = '{1'b0, 1'b0, 32'h0,      32'h10,       1'b0, 1'b0, 4'h0, 32'h14,      1'b1, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 32'h0,      32'hFFFF_FFFC,1'b0, 1'b0, 4'h0, 32'h0,       1'b1, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 32'h0,      32'h10,       1'b0, 1'b0, 4'h0, 32'h14,      1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 32'h200,    32'h10,       1'b0, 1'b0, 4'h0, 32'h200,     1'b1, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 32'h200,    32'h10,       1'b0, 1'b0, 4'h0, 32'h200,     1'b0, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 32'h0,      32'h20,       1'b1, 1'b0, 4'h0, 32'h24,      1'b1, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 32'h0,      32'h30,       1'b0, 1'b0, 4'hF, 32'h34,      1'b1, 1'b0};
        tbl[7] = '{1'b0, 1'b0, 32'h0,      32'h50,       1'b0, 1'b1, 4'h0, 32'h54,      1'b1, 1'b0};
        tbl[8] = '{1'b1, 1'b0, 32'h0,      32'h60,       1'b0, 1'b1, 4'h1, 32'h64,      1'b0, 1'b0};

        in_rst = 1'b0;
        drv(0, 0, 0, 32'h10, 0, 0, 4'h0);
        cyc("rst_out", 0, 0, 0, 32'h10, 0, 0, 4'h0, 32'h0, 1, 0, 0);
        chk("rst_epc", o_epc, 32'h0);
        chk("rst_cause", 32'(o_cause), 32'h0);
        chk("rst_in_isr", 32'(o_in_isr), 32'h0);
        chk("rst_ack", 32'(o_irq_ack), 32'h0);
        tick();
        tick();
        in_rst = 1'b1;

        for (int i = 0; i < 9; i++) begin
            cyc($sformatf("vec%0d", i), tbl[i].stall, tbl[i].br, tbl[i].tgt, tbl[i].pc, tbl[i].mret,
                tbl[i].ie, tbl[i].irq, tbl[i].nxt, tbl[i].en, tbl[i].en, tbl[i].fl);
            tick();
        end
        chk("tbl_no_entry_isr", 32'(o_in_isr), 32'h0);
        chk("tbl_no_entry_epc", o_epc, 32'h0);

        cyc("irq_req", 0, 0, 0, 32'h40, 0, 1, 4'b0110, 32'h0, 0, 0, 0);
        tick();
        cyc("drain1", 0, 0, 0, 32'h40, 0, 1, 4'b0001, 32'h0, 0, 0, 1);
        chk("irq_epc", o_epc, 32'h44);
        chk("irq_cause", 32'(o_cause), 32'h1);
        chk("drain_in_isr", 32'(o_in_isr), 32'h0);
        tick();
        cyc("drain2", 0, 0, 0, 32'h40, 0, 1, 4'b0001, 32'h0, 0, 0, 1);
        tick();
        cyc("enter", 0, 0, 0, 32'h40, 0, 1, 4'b0001, 32'h110, 1, 1, 1);
        chk("enter_ack", 32'(o_irq_ack), 32'h0);
        tick();
        cyc("isr_seq", 0, 0, 0, 32'h110, 0, 1, 4'b0001, 32'h114, 1, 1, 0);
        chk("isr_ack", 32'(o_irq_ack), 32'h2);
        chk("isr_in_isr", 32'(o_in_isr), 32'h1);
        tick();
        cyc("isr_br", 0, 1, 32'h180, 32'h114, 0, 1, 4'b0001, 32'h180, 1, 1, 0);
        chk("ack_one_cycle", 32'(o_irq_ack), 32'h0);
        tick();
        cyc("mret", 0, 1, 32'h500, 32'h120, 1, 1, 4'b0001, 32'h44, 1, 1, 1);
        tick();
        cyc("b2b_req", 0, 0, 0, 32'h200, 0, 1, 4'b0001, 32'h0, 0, 0, 0);
        chk("mret_in_isr", 32'(o_in_isr), 32'h0);
        tick();
        cyc("b2b_drain", 0, 0, 0, 32'h200, 0, 1, 4'b0001, 32'h0, 0, 0, 1);
        chk("b2b_epc", o_epc, 32'h204);
        chk("b2b_cause", 32'(o_cause), 32'h0);
        in_rst = 1'b0;
        sb.push_back('{nxt: 32'h0, care: 1'b1, en: 1'b0, fl: 1'b0});
        #1;
        pop_chk("async_rst");
        chk("async_rst_epc", o_epc, 32'h0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("rst_no_ack%0d", k), 32'(o_irq_ack), 32'h0);
            chk($sformatf("rst_no_isr%0d", k), 32'(o_in_isr), 32'h0);
        end
        drv(0, 0, 0, 32'h10, 0, 0, 4'b0001);
        in_rst = 1'b1;
        tick();
        cyc("post_rst", 0, 0, 0, 32'h10, 0, 0, 4'b0001, 32'h14, 1, 1, 0);
        tick();

        cyc("irq_br", 0, 1, 32'h300, 32'h80, 0, 1, 4'b1000, 32'h0, 0, 0, 0);
        tick();
        chk("br_epc", o_epc, 32'h300);
        chk("br_cause", 32'(o_cause), 32'h3);
        found = -1;
        for (int k = 1; k <= 15; k++) begin
            drv(k >= 2 && k <= 4, 0, 0, 32'h80, 0, 1, 4'h0);
            #3;
            if (o_pc_enable && o_flush) begin
                found = k;
                break;
            end
            tick();
        end
        chk("stall_vec_delay", 32'(found), 32'd6);
        chk("stall_vec_addr", o_nxt_pc, 32'h130);
        tick();
        chk("br_ack", 32'(o_irq_ack), 32'h8);
        cyc("mret_stall1", 1, 0, 0, 32'h130, 1, 1, 4'h0, 32'h0, 0, 0, 0);
        tick();
        cyc("mret_stall2", 1, 0, 0, 32'h130, 1, 1, 4'h0, 32'h0, 0, 0, 0);
        tick();
        chk("mret_stall_isr", 32'(o_in_isr), 32'h1);
        cyc("mret_go", 0, 0, 0, 32'h134, 1, 1, 4'h0, 32'h300, 1, 1, 1);
        tick();
        chk("mret_go_isr", 32'(o_in_isr), 32'h0);
        cyc("run_mret_nop", 0, 0, 0, 32'h300, 1, 0, 4'h0, 32'h304, 1, 1, 0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
